// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PAR_NONE  = 0;
    localparam int PAR_EVEN  = 1;
    localparam int PAR_ODD   = 2;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the request source and the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: none in the bundle; the source watches busy, and requests seen while busy are dropped.
//   start : one-cycle send request
//   data  : byte to send, sampled with start
//   tx    : serial line, idle high
//   busy  : frame in progress
//   done  : one-cycle pulse after the stop bit
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic                 start;
    logic [DATA_BITS-1:0] data;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (output start, output data, input tx, input busy, input done);
    modport slave  (input start, input data, output tx, output busy, output done);

endinterface

// File: rtl/uart_tx_ctrl_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last count.
// Latency: bit_tick is combinational on the count; asserted during the cycle whose closing edge is the bit boundary.
// Backpressure: none; clr restarts the period and en freezes the count.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count at 0 on the next edge
//   en       : count enable
//   bit_tick : high for one cycle when the count sits at CLKS_PER_BIT-1
module baud_gen #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    assign bit_tick = en && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (bit_tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: latches a byte on start and sends start, 8 data bits LSB-first, optional parity, stop.
// Latency: tx falls and busy rises one cycle after the accepting edge; frame is 10 or 11 bit periods.
// Backpressure: start while busy is dropped (not queued); done pulses once per completed frame.
//   clk, rst : clock, synchronous active-high reset
//   u        : slave side of uart_tx_ctrl_if (start/data in, tx/busy/done out, all outputs registered)
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int PARITY       = 0
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  u
);
    import uart_pkg::*;

    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_ctrl: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_tx_ctrl: CLKS_PER_BIT must be in 2..65535");
    end

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           bit_cnt;
    logic                 par_acc;
    logic                 par_nxt;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 accept;
    logic                 bit_tick;

    assign accept  = (state == IDLE) && u.start;
    // Parity including the bit leaving on this boundary; used when the last data bit ends.
    assign par_nxt = par_acc ^ shift[0];

    baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (state != IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            par_acc <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (u.start) begin
                        shift   <= u.data;
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_q  <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift   <= shift >> 1;
                        par_acc <= par_nxt;
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY != PAR_NONE) begin
                                tx_q  <= (PARITY == PAR_ODD) ? ~par_nxt : par_nxt;
                                state <= uart_pkg::PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            // shift[1] becomes shift[0] on this same edge.
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_q    <= shift[1];
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (bit_tick) begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign u.tx   = tx_q;
    assign u.busy = busy_q;
    assign u.done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4, one instance per parity mode.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_ctrl;

    localparam int C = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    uart_tx_ctrl_if if0 ();
    uart_tx_ctrl_if if1 ();
    uart_tx_ctrl_if if2 ();

    uart_tx_ctrl #(.CLKS_PER_BIT(C), .PARITY(0)) u_dut0 (.clk(clk), .rst(rst), .u(if0));
    uart_tx_ctrl #(.CLKS_PER_BIT(C), .PARITY(1)) u_dut1 (.clk(clk), .rst(rst), .u(if1));
    uart_tx_ctrl #(.CLKS_PER_BIT(C), .PARITY(2)) u_dut2 (.clk(clk), .rst(rst), .u(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {tx, busy, done} of the selected instance
    function automatic logic [2:0] obs(input int sel);
        case (sel)
            0:       return {if0.tx, if0.busy, if0.done};
            1:       return {if1.tx, if1.busy, if1.done};
            default: return {if2.tx, if2.busy, if2.done};
        endcase
    endfunction

    task automatic set_start(input int sel, input logic s);
        case (sel)
            0:       if0.start = s;
            1:       if1.start = s;
            default: if2.start = s;
        endcase
    endtask

    task automatic set_data(input int sel, input logic [7:0] d);
        case (sel)
            0:       if0.data = d;
            1:       if1.data = d;
            default: if2.data = d;
        endcase
    endtask

    // Start is held across exactly one rising edge (edge k); returns right after edge k.
    task automatic launch(input int sel, input logic [7:0] d);
        @(negedge clk);
        set_data(sel, d);
        set_start(sel, 1'b1);
        @(posedge clk);
    endtask

    // Watches cycles c = 0 .. nslots*C (cycle c follows edge k+c). Optionally raises
    // start with inj_d during cycle inj_c so that edge k+inj_c+1 samples it.
    task automatic observe(input int sel, input int nslots, input int inj_c, input logic [7:0] inj_d,
                           output logic [10:0] slots, output int busy_cnt, output int done_pos,
                           output int done_cnt, output bit stable, output logic idle_tx);
        logic [2:0] o;
        logic       first;
        slots = '0; busy_cnt = 0; done_pos = -1; done_cnt = 0; stable = 1'b1;
        idle_tx = 1'b0; first = 1'b0;
        for (int c = 0; c <= nslots * C; c++) begin
            @(negedge clk);
            if (c == 0 || c == inj_c + 1) set_start(sel, 1'b0);
            o = obs(sel);
            if (c < nslots * C) begin
                if (c % C == 0) begin
                    first = o[2];
                    slots[c / C] = o[2];
                end else if (o[2] !== first) begin
                    stable = 1'b0;
                end
            end else begin
                idle_tx = o[2];
            end
            if (o[1]) busy_cnt++;
            if (o[0]) begin
                done_cnt++;
                done_pos = c;
            end
            if (c == inj_c) begin
                set_data(sel, inj_d);
                set_start(sel, 1'b1);
            end
        end
    endtask

    task automatic frame_checks(input string tag, input int nslots, input logic [10:0] exp_slots,
                                input logic [10:0] slots, input int busy_cnt, input int done_pos,
                                input int done_cnt, input bit stable, input logic idle_tx);
        chk({tag, "_slots"}, 32'(slots), 32'(exp_slots));
        chk({tag, "_slot_stable"}, 32'(stable), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(nslots * C));
        chk({tag, "_done_pos"}, 32'(done_pos), 32'(nslots * C));
        chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, "_idle_tx"}, 32'(idle_tx), 32'd1);
    endtask

    task automatic idle_check(input int sel, input string tag);
        @(negedge clk);
        chk(tag, 32'(obs(sel)), 32'b100);
    endtask

    initial begin
        logic [10:0] slots;
        int          busy_cnt, done_pos, done_cnt, n_done, n_low;
        bit          stable;
        logic        idle_tx;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        if0.start = 1'b0; if0.data = 8'h00;
        if1.start = 1'b0; if1.data = 8'h00;
        if2.start = 1'b0; if2.data = 8'h00;

        // Reset held 3 cycles, with start raised on the same edges: reset must win.
        @(negedge clk);
        if0.start = 1'b1;
        if0.data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_hold", 32'(obs(0)), 32'b100);
        end
        rst = 1'b0;
        if0.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_reset_dut0", 32'(obs(0)), 32'b100);
            chk("post_reset_dut1", 32'(obs(1)), 32'b100);
            chk("post_reset_dut2", 32'(obs(2)), 32'b100);
        end

        // No parity, 0xA5: slots 0,1,0,1,0,0,1,0,1,1.
        launch(0, 8'hA5);
        observe(0, 10, -10, 8'h00, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        frame_checks("a5_none", 10, 11'h34A, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        idle_check(0, "a5_none_after");

        // Even parity, 0x07: three ones -> parity slot 1.
        launch(1, 8'h07);
        observe(1, 11, -10, 8'h00, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        frame_checks("07_even", 11, 11'h60E, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        idle_check(1, "07_even_after");

        // Odd parity, 0x07: parity slot 0.
        launch(2, 8'h07);
        observe(2, 11, -10, 8'h00, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        frame_checks("07_odd", 11, 11'h40E, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        idle_check(2, "07_odd_after");

        // Start with 0xFF at edge k+12 of a 0x00 frame: dropped, not queued.
        launch(0, 8'h00);
        observe(0, 10, 11, 8'hFF, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        frame_checks("ignored", 10, 11'h200, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        idle_check(0, "ignored_after");
        idle_check(0, "ignored_after2");

        // Start raised in the done cycle: back-to-back frames, one idle-high cycle between.
        launch(0, 8'h81);
        observe(0, 10, 10 * C, 8'h3C, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        frame_checks("chain1", 10, 11'h302, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        observe(0, 10, -10, 8'h00, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        frame_checks("chain2", 10, 11'h278, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        idle_check(0, "chain_after");

        // Reset during data bit 3 (slot 4), then a clean frame.
        launch(0, 8'h5A);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) if0.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midframe_reset", 32'(obs(0)), 32'b100);
        rst = 1'b0;
        n_done = 0;
        n_low  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (if0.done) n_done++;
            if (!if0.tx || if0.busy) n_low++;
        end
        chk("midframe_no_done", 32'(n_done), 32'd0);
        chk("midframe_stays_idle", 32'(n_low), 32'd0);
        launch(0, 8'h5A);
        observe(0, 10, -10, 8'h00, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        frame_checks("after_reset", 10, 11'h2B4, slots, busy_cnt, done_pos, done_cnt, stable, idle_tx);
        idle_check(0, "after_reset_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
